// File: rtl/c0_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a Wishbone slave and a simple core port.
// One command is in flight at a time; reads take IDLE->CMD->DATA->RESP and writes take IDLE->CMD->RESP.
module c0_sram_arbiter #(
  parameter int unsigned AW = 13
) (
  input  logic          clk_g,
  input  logic          rst_g,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          core_valid,
  input  logic [31:0]   core_addr,
  input  logic [31:0]   core_wdata,
  input  logic [3:0]    core_wstrb,
  output logic          core_ready,
  output logic [31:0]   core_rdata,
  output logic          sram_csb0,
  output logic          sram_web0,
  output logic [3:0]    sram_wmask0,
  output logic [AW-1:0] sram_addr0,
  output logic [31:0]   sram_din0,
  input  logic [31:0]   sram_dout0
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, RESP} state_t;

  state_t      state;
  logic        last_wb;
  logic        grant_wb;
  logic        is_write;
  logic        wb_resp;
  logic [31:0] rdata_q;

  logic          wb_req;
  logic          core_req;
  logic          pick_wb;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_data;
  logic [3:0]    sel_mask;

  assign wb_req   = wbs_cyc_i & wbs_stb_i;
  assign core_req = core_valid;
  // On a tie the requester that was not granted last wins.
  assign pick_wb  = wb_req & (~core_req | ~last_wb);

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_mask  = '0;
    if (pick_wb) begin
      sel_write = wbs_we_i;
      sel_addr  = wbs_adr_i[AW+1:2];
      sel_data  = wbs_dat_i;
      sel_mask  = wbs_we_i ? wbs_sel_i : 4'b0000;
    end else begin
      sel_write = |core_wstrb;
      sel_addr  = core_addr[AW+1:2];
      sel_data  = core_wdata;
      sel_mask  = core_wstrb;
    end
  end

  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      state       <= IDLE;
      last_wb     <= 1'b1;
      grant_wb    <= 1'b0;
      is_write    <= 1'b0;
      wb_resp     <= 1'b0;
      core_ready  <= 1'b0;
      rdata_q     <= '0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_req | core_req) begin
            grant_wb    <= pick_wb;
            last_wb     <= pick_wb;
            is_write    <= sel_write;
            sram_csb0   <= 1'b0;
            sram_web0   <= ~sel_write;
            sram_wmask0 <= sel_mask;
            sram_addr0  <= sel_addr;
            sram_din0   <= sel_data;
            state       <= CMD;
          end
        end
        CMD: begin
          sram_csb0 <= 1'b1;
          sram_web0 <= 1'b1;
          if (is_write) begin
            wb_resp    <= grant_wb;
            core_ready <= ~grant_wb;
            state      <= RESP;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          rdata_q    <= sram_dout0;
          wb_resp    <= grant_wb;
          core_ready <= ~grant_wb;
          state      <= RESP;
        end
        default: begin
          wb_resp    <= 1'b0;
          core_ready <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // A master that abandoned its cycle never sees the ack of the access it started.
  assign wbs_ack_o  = wb_resp & wb_req;
  assign wbs_dat_o  = rdata_q;
  assign core_rdata = rdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, wbs_adr_i[31:AW+2], wbs_adr_i[1:0],
                              core_addr[31:AW+2], core_addr[1:0]};

endmodule

// File: tb/tb_c0_sram_arbiter.sv
// Directed bench for c0_sram_arbiter: a table of single transactions plus tie, reset and abandon sequences.
module tb_c0_sram_arbiter;

  logic        clk_g = 1'b0;
  logic        rst_g;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_valid;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_ready;
  logic [31:0] core_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [12:0] sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  c0_sram_arbiter #(.AW(13)) dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_valid(core_valid), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_wstrb(core_wstrb), .core_ready(core_ready), .core_rdata(core_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk_g = ~clk_g;

  // Behavioural single-port SRAM: read data appears the cycle after the command.
  logic [31:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    sram_dout0 = '0;
  end
  always @(posedge clk_g) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  typedef struct {
    bit          is_core;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_a0;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  int n_cmp  = 0;
  int n_miss = 0;
  logic [31:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = '0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    core_valid = 0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
  endtask

  task automatic drive(input vec_t v);
    if (v.is_core) begin
      core_valid = 1; core_addr = v.addr; core_wdata = v.data;
      core_wstrb = v.we ? v.mask : 4'h0;
    end else begin
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = v.we; wbs_sel_i = v.mask;
      wbs_adr_i = v.addr; wbs_dat_i = v.data;
    end
  endtask

  task automatic run_txn(input int id, input vec_t v);
    int   lat;
    bit   done;
    logic other_seen;
    logic own, other;
    @(negedge clk_g);
    drive(v);
    @(posedge clk_g);
    lat = 0; done = 0; other_seen = 0;
    while (!done && lat < 10) begin
      @(negedge clk_g);
      lat++;
      if (lat == 1) begin
        chk($sformatf("v%0d_csb_cmd", id), {31'b0, sram_csb0}, 32'd0);
        chk($sformatf("v%0d_web", id), {31'b0, sram_web0}, {31'b0, ~v.we});
        chk($sformatf("v%0d_addr0", id), {19'b0, sram_addr0}, v.exp_a0);
        chk($sformatf("v%0d_wmask", id), {28'b0, sram_wmask0}, v.we ? {28'b0, v.mask} : 32'd0);
        if (v.we) chk($sformatf("v%0d_din", id), sram_din0, v.data);
      end
      if (lat == 2) chk($sformatf("v%0d_csb_after", id), {31'b0, sram_csb0}, 32'd1);
      own   = v.is_core ? core_ready : wbs_ack_o;
      other = v.is_core ? wbs_ack_o  : core_ready;
      if (other) other_seen = 1;
      if (own) done = 1;
    end
    chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d_other_resp", id), {31'b0, other_seen}, 32'd0);
    if (!v.we) last_rd = v.exp_rd;
    chk($sformatf("v%0d_wbs_dat", id), wbs_dat_o, last_rd);
    chk($sformatf("v%0d_core_rdata", id), core_rdata, last_rd);
    idle_inputs();
  endtask

  vec_t tbl [13];
  vec_t v;
  int   order [4];
  int   got;
  logic both_seen, ack_seen, rdy_seen;

  initial begin
    tbl[0]  = '{1, 1, 32'h10,       32'hDEADBEEF, 4'hF, 32'd4, 32'h0,        2};
    tbl[1]  = '{0, 0, 32'h10,       32'h0,        4'hF, 32'd4, 32'hDEADBEEF, 3};
    tbl[2]  = '{0, 1, 32'h10,       32'h0000AB00, 4'h2, 32'd4, 32'h0,        2};
    tbl[3]  = '{0, 0, 32'h10,       32'h0,        4'hF, 32'd4, 32'hDEADABEF, 3};
    tbl[4]  = '{1, 0, 32'h10,       32'h0,        4'h0, 32'd4, 32'hDEADABEF, 3};
    tbl[5]  = '{0, 1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'd4, 32'h0,        2};
    tbl[6]  = '{1, 0, 32'h10,       32'h0,        4'h0, 32'd4, 32'hDEADABEF, 3};
    tbl[7]  = '{0, 1, 32'hFFFF8004, 32'h12345678, 4'hF, 32'd1, 32'h0,        2};
    tbl[8]  = '{1, 0, 32'h4,        32'h0,        4'h0, 32'd1, 32'h12345678, 3};
    tbl[9]  = '{1, 1, 32'h4,        32'hAA000000, 4'h8, 32'd1, 32'h0,        2};
    tbl[10] = '{0, 0, 32'h4,        32'h0,        4'hF, 32'd1, 32'hAA345678, 3};
    tbl[11] = '{1, 0, 32'h20,       32'h0,        4'h0, 32'd8, 32'h11111111, 3};
    tbl[12] = '{0, 0, 32'h24,       32'h0,        4'hF, 32'd9, 32'h22222222, 3};

    idle_inputs();
    last_rd = '0;
    rst_g = 1;
    repeat (3) @(posedge clk_g);
    @(negedge clk_g);
    chk("rst_csb", {31'b0, sram_csb0}, 32'd1);
    chk("rst_web", {31'b0, sram_web0}, 32'd1);
    chk("rst_wmask", {28'b0, sram_wmask0}, 32'd0);
    chk("rst_addr0", {19'b0, sram_addr0}, 32'd0);
    chk("rst_din", sram_din0, 32'd0);
    chk("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    chk("rst_ready", {31'b0, core_ready}, 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    rst_g = 0;

    // Persistent tie straight after reset: core, WB, core, WB.
    order = '{1, 2, 1, 2};
    core_valid = 1; core_addr = 32'h20; core_wdata = 32'h11111111; core_wstrb = 4'hF;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h24; wbs_dat_i = 32'h22222222;
    got = 0; both_seen = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk_g);
      if (core_ready && wbs_ack_o) both_seen = 1;
      if (core_ready || wbs_ack_o) begin
        chk($sformatf("tie_order_%0d", got), core_ready ? 32'd1 : 32'd2, order[got]);
        got++;
      end
    end
    idle_inputs();
    chk("tie_count", got, 4);
    chk("tie_both", {31'b0, both_seen}, 32'd0);

    for (int i = 0; i < 13; i++) run_txn(i, tbl[i]);

    // Reset during DATA of a WB read, then reissue.
    @(negedge clk_g);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h10;
    @(posedge clk_g);
    @(posedge clk_g);
    @(negedge clk_g);
    rst_g = 1;
    @(negedge clk_g);
    chk("rstdata_ack", {31'b0, wbs_ack_o}, 32'd0);
    chk("rstdata_csb", {31'b0, sram_csb0}, 32'd1);
    chk("rstdata_dat", wbs_dat_o, 32'd0);
    chk("rstdata_ready", {31'b0, core_ready}, 32'd0);
    rst_g = 0;
    idle_inputs();
    last_rd = '0;
    v = '{0, 0, 32'h10, 32'h0, 4'hF, 32'd4, 32'hDEADABEF, 3};
    run_txn(20, v);

    // WB master abandons the cycle while the command is on the SRAM.
    @(negedge clk_g);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h4;
    @(posedge clk_g);
    @(negedge clk_g);
    chk("drop_csb_cmd", {31'b0, sram_csb0}, 32'd0);
    idle_inputs();
    ack_seen = 0; rdy_seen = 0;
    repeat (6) begin
      @(negedge clk_g);
      if (wbs_ack_o) ack_seen = 1;
      if (core_ready) rdy_seen = 1;
    end
    chk("drop_no_ack", {31'b0, ack_seen}, 32'd0);
    chk("drop_no_ready", {31'b0, rdy_seen}, 32'd0);
    chk("drop_read_done", wbs_dat_o, 32'hAA345678);
    last_rd = 32'hAA345678;
    v = '{1, 1, 32'h30, 32'h00000055, 4'hF, 32'd12, 32'h0, 2};
    run_txn(21, v);
    v = '{1, 0, 32'h30, 32'h0, 4'h0, 32'd12, 32'h00000055, 3};
    run_txn(22, v);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
